// File: rtl/ap_ctrl_txn_profiler.sv
// Profiles ap_ctrl_hs/ap_ctrl_chain transactions into {aborted, stall, done_lat, ready_lat, start_ts} records.
// Latency: a record pushed at the edge ending cycle N is presented on rec_valid/rec_data in cycle N+1.
// Backpressure: records queue in a DEPTH-entry FIFO; a push into a full, non-popping FIFO is dropped and counted.
module ap_ctrl_txn_profiler #(
    parameter int TS_W  = 32,
    parameter int CNT_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        mon_ap_start,
    input  logic                        mon_ap_ready,
    input  logic                        mon_ap_done,
    input  logic                        mon_ap_continue,
    input  logic                        finish,
    output logic                        rec_valid,
    input  logic                        rec_ready,
    output logic [TS_W+3*CNT_W:0]       rec_data,
    output logic [CNT_W-1:0]            txn_count,
    output logic [CNT_W-1:0]            drop_count
);
    localparam int REC_W = TS_W + 3*CNT_W + 1;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAIT_CONT, S_STOPPED} state_t;

    state_t             state_q, state_d;
    logic [TS_W-1:0]    ts_q;
    logic [TS_W-1:0]    start_ts_q, start_ts_d;
    logic [CNT_W-1:0]   off_q, off_d;
    logic               ready_seen_q, ready_seen_d;
    logic [CNT_W-1:0]   ready_lat_q, ready_lat_d;
    logic [CNT_W-1:0]   done_lat_q, done_lat_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [REC_W-1:0]   mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   txn_count_q, drop_count_q;

    // Combinational helpers for the record being built this cycle
    logic               active, push, rec_ab;
    logic [TS_W-1:0]    cur_start;
    logic [CNT_W-1:0]   cur_off, cur_rl, rl_now, stall_now;
    logic               cur_seen;
    logic [REC_W-1:0]   rec_new;
    logic               fifo_full, fifo_empty, pop, push_ok, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Next-state and record assembly; IDLE+start is treated as cycle 0 of BUSY
    always_comb begin
        state_d      = state_q;
        start_ts_d   = start_ts_q;
        off_d        = off_q;
        ready_seen_d = ready_seen_q;
        ready_lat_d  = ready_lat_q;
        done_lat_d   = done_lat_q;
        stall_d      = stall_q;
        active       = 1'b0;
        push         = 1'b0;
        rec_ab       = 1'b0;
        cur_start    = start_ts_q;
        cur_off      = off_q;
        cur_seen     = ready_seen_q;
        cur_rl       = ready_lat_q;
        rl_now       = ready_lat_q;
        stall_now    = sat_inc(stall_q);
        rec_new      = {1'b0, stall_q, done_lat_q, ready_lat_q, start_ts_q};
        case (state_q)
            S_IDLE: begin
                if (finish) begin
                    state_d = S_STOPPED;
                end else if (mon_ap_start) begin
                    active    = 1'b1;
                    cur_start = ts_q;
                    cur_off   = '0;
                    cur_seen  = 1'b0;
                end
            end
            S_BUSY: active = 1'b1;
            S_WAIT_CONT: begin
                stall_d = stall_now;
                rec_new = {1'b0, stall_now, done_lat_q, ready_lat_q, start_ts_q};
                if (mon_ap_continue) begin
                    push    = 1'b1;
                    state_d = finish ? S_STOPPED : S_IDLE;
                end else if (finish) begin
                    push    = 1'b1;
                    rec_ab  = 1'b1;
                    state_d = S_STOPPED;
                end
            end
            default: state_d = S_STOPPED;
        endcase
        if (active) begin
            // An unseen ready reports the running offset, which also covers done-without-ready
            rl_now       = cur_seen ? cur_rl : cur_off;
            start_ts_d   = cur_start;
            ready_seen_d = cur_seen | mon_ap_ready;
            ready_lat_d  = rl_now;
            done_lat_d   = cur_off;
            off_d        = sat_inc(cur_off);
            stall_d      = '0;
            state_d      = S_BUSY;
            if (mon_ap_done) begin
                if (mon_ap_continue || finish) push = 1'b1;
                state_d = finish ? S_STOPPED : (mon_ap_continue ? S_IDLE : S_WAIT_CONT);
            end else if (finish) begin
                push    = 1'b1;
                rec_ab  = 1'b1;
                state_d = S_STOPPED;
            end
        end
        if (state_q != S_WAIT_CONT) begin
            rec_new = {rec_ab, {CNT_W{1'b0}}, cur_off, rl_now, cur_start};
        end else begin
            rec_new[REC_W-1] = rec_ab;
        end
    end

    // State register, timestamp and per-transaction field latches
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q      <= S_IDLE;
            ts_q         <= '0;
            start_ts_q   <= '0;
            off_q        <= '0;
            ready_seen_q <= 1'b0;
            ready_lat_q  <= '0;
            done_lat_q   <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_q + {{(TS_W-1){1'b0}}, 1'b1};
            start_ts_q   <= start_ts_d;
            off_q        <= off_d;
            ready_seen_q <= ready_seen_d;
            ready_lat_q  <= ready_lat_d;
            done_lat_q   <= done_lat_d;
            stall_q      <= stall_d;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && rec_ready;
    assign push_ok    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    // Record FIFO storage and pointers; a full FIFO that pops accepts the push too
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= rec_new;
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop) rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Saturating transaction and drop counters
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            txn_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            if (push) txn_count_q  <= sat_inc(txn_count_q);
            if (drop) drop_count_q <= sat_inc(drop_count_q);
        end
    end

    assign rec_valid  = !fifo_empty;
    assign rec_data   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign txn_count  = txn_count_q;
    assign drop_count = drop_count_q;
endmodule
